// File: rtl/twos_to_adc_offset.sv
// Two's-complement to offset-binary converter with one registered stage and valid qualifier.
// The mapping only inverts the sign bit of the active field, so it is its own inverse.
module twos_to_adc_offset #(
  parameter int PORT_WIDTH = 14,
  parameter int WIRE_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic [PORT_WIDTH-1:0] data_in,
  output logic [PORT_WIDTH-1:0] data_out,
  output logic                  out_valid
);

  logic [PORT_WIDTH-1:0] w_conv;
  logic [PORT_WIDTH-1:0] r_data;
  logic                  r_valid;

  always_comb begin
    w_conv                   = '0;
    w_conv[WIRE_WIDTH-2:0]   = data_in[WIRE_WIDTH-2:0];
    w_conv[WIRE_WIDTH-1]     = ~data_in[WIRE_WIDTH-1];
  end

  // Bits above the active field are deliberately ignored.
  generate
    if (WIRE_WIDTH < PORT_WIDTH) begin : g_upper
      logic w_unused_upper;
      assign w_unused_upper = ^data_in[PORT_WIDTH-1:WIRE_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (en) begin
      r_data  <= w_conv;
      r_valid <= in_valid;
    end
  end

  assign data_out  = r_data;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_twos_to_adc_offset.sv
// Self-checking bench: 12-bit and 14-bit active-field instances plus a back-to-back pair for the involution sweep.
module tb_twos_to_adc_offset;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        inValid;
  logic [13:0] dataIn;
  logic [13:0] out12, out14, outInv;
  logic        valid12, valid14, validInv;

  int total = 0;
  int bad   = 0;

  logic [13:0] exp12, exp14;
  logic        expValid;

  twos_to_adc_offset #(.PORT_WIDTH(14), .WIRE_WIDTH(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(inValid),
    .data_in(dataIn), .data_out(out12), .out_valid(valid12));

  twos_to_adc_offset #(.PORT_WIDTH(14), .WIRE_WIDTH(14)) dut14 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(inValid),
    .data_in(dataIn), .data_out(out14), .out_valid(valid14));

  twos_to_adc_offset #(.PORT_WIDTH(14), .WIRE_WIDTH(12)) dutInv (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(valid12),
    .data_in(out12), .data_out(outInv), .out_valid(validInv));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: interpret the active field as a signed number and add half scale.
  function automatic logic [13:0] refOffset(input int x, input int w);
    int span = 1 << w;
    int half = span / 2;
    int v    = x % span;
    if (v >= half) v = v - span;
    return 14'(v + half);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, " data12"}, 32'(out12), 32'(exp12));
    checkOutput({tag, " data14"}, 32'(out14), 32'(exp14));
    checkOutput({tag, " valid12"}, 32'(valid12), 32'(expValid));
    checkOutput({tag, " valid14"}, 32'(valid14), 32'(expValid));
  endtask

  // Drive one cycle of inputs, then sample one time unit after the rising edge.
  task automatic applyStimulus(input logic [13:0] d, input logic iv, input logic e);
    dataIn  = d;
    inValid = iv;
    en      = e;
    @(posedge clk);
    if (e && rst_n) begin
      exp12    = refOffset(int'(d), 12);
      exp14    = refOffset(int'(d), 14);
      expValid = iv;
    end
    #1;
  endtask

  logic [13:0] vec12In  [6] = '{14'h0ca3, 14'h0fff, 14'h0000, 14'h0001, 14'h07ff, 14'h0a10};
  logic [13:0] vec12Out [6] = '{14'h04a3, 14'h07ff, 14'h0800, 14'h0801, 14'h0fff, 14'h0210};
  logic [13:0] vec14In  [4] = '{14'h2000, 14'h0000, 14'h1fff, 14'h3fff};
  logic [13:0] vec14Out [4] = '{14'h0000, 14'h2000, 14'h3fff, 14'h1fff};
  logic [13:0] inFlight [$];

  initial begin
    rst_n = 1'b0; en = 1'b1; inValid = 1'b1; dataIn = 14'h0ca3;
    exp12 = '0; exp14 = '0; expValid = 1'b0;
    #1;
    checkAll("reset immediate");
    @(posedge clk); #1;
    checkAll("reset held");
    rst_n = 1'b1;
    checkAll("reset released");

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vec12In[i], 1'b1, 1'b1);
      checkOutput($sformatf("w12 vec%0d", i), 32'(out12), 32'(vec12Out[i]));
      checkAll("w12 model");
    end

    applyStimulus(14'h3ca3, 1'b1, 1'b1);
    checkOutput("mask 3ca3", 32'(out12), 32'h04a3);
    applyStimulus(14'h2000, 1'b1, 1'b1);
    checkOutput("mask 2000", 32'(out12), 32'h0800);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vec14In[i], 1'b1, 1'b1);
      checkOutput($sformatf("w14 vec%0d", i), 32'(out14), 32'(vec14Out[i]));
    end

    applyStimulus(14'h0111, 1'b1, 1'b1);
    checkOutput("vpat 1", 32'(valid12), 32'd1);
    applyStimulus(14'h0222, 1'b0, 1'b1);
    checkOutput("vpat 0", 32'(valid12), 32'd0);
    checkOutput("vpat 0 data", 32'(out12), 32'h0a22);
    applyStimulus(14'h0333, 1'b1, 1'b0);
    checkOutput("vpat stall", 32'(valid12), 32'd0);
    checkOutput("vpat stall data", 32'(out12), 32'h0a22);
    applyStimulus(14'h0333, 1'b1, 1'b1);
    checkOutput("vpat 1b", 32'(valid12), 32'd1);
    applyStimulus(14'h0444, 1'b1, 1'b1);
    checkOutput("vpat 1c", 32'(valid12), 32'd1);
    checkOutput("vpat 1c data", 32'(out12), 32'h0c44);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(14'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
      checkAll("random");
    end

    applyStimulus(14'h0ca3, 1'b1, 1'b1);
    checkAll("pre-reset");
    #2 rst_n = 1'b0;
    exp12 = '0; exp14 = '0; expValid = 1'b0;
    #1;
    checkAll("midstream reset");
    applyStimulus(14'h0555, 1'b1, 1'b1);
    checkAll("reset during edge");
    rst_n = 1'b1;
    checkAll("after release");
    applyStimulus(14'h0777, 1'b1, 1'b1);
    checkAll("first after reset");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(14'($urandom), 1'($urandom), 1'b0);
      checkAll("enable low hold");
    end

    for (int i = 0; i < 4096; i++) begin
      inFlight.push_back(14'(i));
      applyStimulus({2'($urandom), 12'(i)}, 1'b1, 1'b1);
      if (inFlight.size() == 2) begin
        logic [13:0] orig;
        orig = inFlight.pop_front();
        checkOutput($sformatf("involution 0x%0h", orig), 32'(outInv), 32'(orig));
      end
    end
    applyStimulus(14'h0000, 1'b1, 1'b1);
    if (inFlight.size() == 1) begin
      logic [13:0] orig;
      orig = inFlight.pop_front();
      checkOutput("involution last", 32'(outInv), 32'(orig));
    end
    checkOutput("involution valid", 32'(validInv), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
